// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: dump FSM states and the legal
// byte-enable patterns used when DMEM_MISALIGN_CHECK_EN is defined.
package dmem_pkg;

  localparam int unsigned DMEM_WORD_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StDone
  } dump_state_e;

  localparam logic [3:0] DweNone  = 4'b0000;
  localparam logic [3:0] DweByte0 = 4'b0001;
  localparam logic [3:0] DweByte1 = 4'b0010;
  localparam logic [3:0] DweByte2 = 4'b0100;
  localparam logic [3:0] DweByte3 = 4'b1000;
  localparam logic [3:0] DweHalf0 = 4'b0011;
  localparam logic [3:0] DweHalf1 = 4'b1100;
  localparam logic [3:0] DweWord  = 4'b1111;

  function automatic logic dwe_is_legal(input logic [3:0] dwe);
    return dwe inside {DweNone, DweByte0, DweByte1, DweByte2, DweByte3,
                       DweHalf0, DweHalf1, DweWord};
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One 8-bit lane of the data memory: synchronous write, two asynchronous read ports
// (CPU side and dump side).
module dmem_bank #(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr_a,
  output logic [7:0]            o_rdata_a,
  input  logic [DEPTH_LOG2-1:0] i_raddr_b,
  output logic [7:0]            o_rdata_b
);

  logic [7:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/dmem_dump_responder.sv
// Data-memory responder with byte-lane CPU port and a valid/ready dump engine.
// Define DMEM_MISALIGN_CHECK_EN to reject illegal byte-enable patterns and flag err_misalign.
module dmem_dump_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned DUMP_BASE  = 0,
  parameter int unsigned DUMP_WORDS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            daddr,
  output logic [DMEM_WORD_W-1:0] drdata,
  input  logic [DMEM_WORD_W-1:0] dwdata,
  input  logic [3:0]             dwe,
  input  logic                   dump_start,
  output logic                   dump_busy,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [31:0]            dump_addr,
  output logic [DMEM_WORD_W-1:0] dump_data,
  output logic                   dump_done,
  output logic                   err_misalign
);

  localparam logic [DEPTH_LOG2-1:0] BaseIdx = DEPTH_LOG2'(DUMP_BASE);
  localparam logic [DEPTH_LOG2-1:0] LastCnt = DEPTH_LOG2'(DUMP_WORDS - 1);

  logic [DEPTH_LOG2-1:0]  w_cpu_idx;
  logic [DEPTH_LOG2-1:0]  w_dump_idx;
  logic [3:0]             w_lane_we;
  logic [7:0]             w_cpu_lane  [4];
  logic [7:0]             w_dump_lane [4];
  logic [DMEM_WORD_W-1:0] w_dump_word;
  logic                   w_unused_daddr;

  dump_state_e            r_state;
  logic [DEPTH_LOG2-1:0]  r_cnt;
  logic                   r_valid;
  logic                   r_busy;
  logic                   r_done;
  logic [31:0]            r_addr;
  logic [DMEM_WORD_W-1:0] r_data;

  // Address bits above the array and the byte offset are ignored, so addresses alias.
  assign w_cpu_idx      = daddr[DEPTH_LOG2+1:2];
  assign w_unused_daddr = ^{daddr[31:DEPTH_LOG2+2], daddr[1:0]};
  assign w_dump_idx     = BaseIdx + r_cnt;

`ifdef DMEM_MISALIGN_CHECK_EN
  logic w_dwe_legal;
  logic r_err;

  assign w_dwe_legal = dwe_is_legal(dwe);
  assign w_lane_we   = w_dwe_legal ? dwe : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (!w_dwe_legal) begin
      r_err <= 1'b1;
    end
  end

  assign err_misalign = r_err;
`else
  assign w_lane_we    = dwe;
  assign err_misalign = 1'b0;
`endif

  for (genvar k = 0; k < 4; k++) begin : g_lane
    dmem_bank #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_bank (
      .i_clk    (clk),
      .i_we     (w_lane_we[k]),
      .i_waddr  (w_cpu_idx),
      .i_wdata  (dwdata[8*k +: 8]),
      .i_raddr_a(w_cpu_idx),
      .o_rdata_a(w_cpu_lane[k]),
      .i_raddr_b(w_dump_idx),
      .o_rdata_b(w_dump_lane[k])
    );
  end

  assign drdata      = {w_cpu_lane[3], w_cpu_lane[2], w_cpu_lane[1], w_cpu_lane[0]};
  assign w_dump_word = {w_dump_lane[3], w_dump_lane[2], w_dump_lane[1], w_dump_lane[0]};

  // Capture in LOAD reads the array before this edge's write lands, so it sees the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (dump_start) begin
            r_state <= StLoad;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StLoad: begin
          r_data  <= w_dump_word;
          r_addr  <= 32'({w_dump_idx, 2'b00});
          r_valid <= 1'b1;
          r_state <= StSend;
        end
        StSend: begin
          if (dump_ready) begin
            r_valid <= 1'b0;
            if (r_cnt == LastCnt) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= StLoad;
            end
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dump_busy  = r_busy;
  assign dump_valid = r_valid;
  assign dump_done  = r_done;
  assign dump_addr  = r_addr;
  assign dump_data  = r_data;

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Self-checking bench for dmem_dump_responder: directed table, dump sequences with stalls,
// writes during dump, reset mid-dump, and randomized CPU traffic against a word-level model.
module tb_dmem_dump_responder;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MisChk = 1'b1;
`else
  localparam bit MisChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic        dump_start = 1'b0;
  logic        dump_ready = 1'b0;
  logic [31:0] drdata;
  logic        dump_busy;
  logic        dump_valid;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        err_misalign;

  dmem_dump_responder dut (
    .clk         (clk),
    .reset       (reset),
    .daddr       (daddr),
    .drdata      (drdata),
    .dwdata      (dwdata),
    .dwe         (dwe),
    .dump_start  (dump_start),
    .dump_busy   (dump_busy),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_done   (dump_done),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_mem [4096];
  logic        m_err = 1'b0;
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  logic [31:0] exp_w [32];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  dwe;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [10];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Word-level model: legal-pattern check, then lane-by-lane merge.
  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d,
                                    input logic [3:0] we);
    int unsigned idx = int'(a[13:2]);
    bit legal = we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0011, 4'b1100, 4'b1111};
    if (MisChk && !legal) begin
      m_err = 1'b1;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      if (we[k]) m_mem[idx][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    mdl_write(a, d, we);
    cyc();
    dwe = 4'b0000;
  endtask

  task automatic start_dump();
    dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < 32; i++) exp_w[i] = m_mem[i];
  endtask

  // Drives ready, records accepted words until dump_done, then checks the pulse width.
  task automatic collect(input string tag, input bit toggle, input bit t3_hook);
    int n = 0;
    bit did = 1'b0;
    bit finished = 1'b0;
    got_addr.delete();
    got_data.delete();
    while (!finished && n < 2000) begin
      if (t3_hook && !did && dump_valid && dump_addr == 32'd20) begin
        dump_ready = 1'b0;
        wr(32'd20, 32'h0000DEAD, 4'hF);
        wr(32'd24, 32'h0000BEEF, 4'hF);
        did = 1'b1;
      end
      dump_ready = toggle ? n[0] : 1'b1;
      if (dump_valid && dump_ready) begin
        got_addr.push_back(dump_addr);
        got_data.push_back(dump_data);
      end
      if (dump_done) finished = 1'b1;
      cyc();
      n++;
    end
    dump_ready = 1'b0;
    chk({tag, " done seen"}, 32'(finished), 32'd1);
    chk({tag, " done one cycle"}, 32'(dump_done), 32'd0);
    chk({tag, " busy after done"}, 32'(dump_busy), 32'd0);
    chk({tag, " count"}, 32'(got_data.size()), 32'd32);
    for (int i = 0; i < got_data.size() && i < 32; i++) begin
      chk($sformatf("%s addr%0d", tag, i), got_addr[i], 32'(i * 4));
      chk($sformatf("%s data%0d", tag, i), got_data[i], exp_w[i]);
    end
  endtask

  initial begin
    tbl[0] = '{32'h0000_0040, 32'hAABBCCDD, 4'hF, 32'h0000_0040, 32'hAABBCCDD, 1'b0};
    tbl[1] = '{32'h0000_0040, 32'h00000011, 4'h1, 32'h0000_0040, 32'hAABBCC11, 1'b0};
    tbl[2] = '{32'h0000_4000, 32'h5A5A5A5A, 4'hF, 32'h0000_0000, 32'h5A5A5A5A, 1'b0};
    tbl[3] = '{32'h0000_0080, 32'h12345678, 4'hF, 32'h0000_0080, 32'h12345678, 1'b0};
    tbl[4] = '{32'h0000_0080, 32'hFFFFFFFF, 4'h6, 32'h0000_0080,
               MisChk ? 32'h12345678 : 32'h12FFFF78, MisChk};
    tbl[5] = '{32'h0000_0044, 32'h01020304, 4'hF, 32'h0000_0044, 32'h01020304, MisChk};
    tbl[6] = '{32'h0000_0044, 32'hA0B0C0D0, 4'hC, 32'h0000_0044, 32'hA0B00304, MisChk};
    tbl[7] = '{32'h0000_0046, 32'h0000EE00, 4'h2, 32'h0000_0044, 32'hA0B0EE04, MisChk};
    tbl[8] = '{32'h0001_0044, 32'h77000000, 4'h8, 32'h0000_0044, 32'h77B0EE04, MisChk};
    tbl[9] = '{32'h0000_0044, 32'hFFFFFFFF, 4'h0, 32'h0000_C044, 32'h77B0EE04, MisChk};

    // Reset state
    cyc();
    cyc();
    chk("rst valid", 32'(dump_valid), 32'd0);
    chk("rst busy", 32'(dump_busy), 32'd0);
    chk("rst done", 32'(dump_done), 32'd0);
    chk("rst data", dump_data, 32'd0);
    chk("rst addr", dump_addr, 32'd0);
    chk("rst err", 32'(err_misalign), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4096; i++) begin
      wr(32'(i * 4), (i < 32) ? 32'(i * 3) : $urandom, 4'hF);
    end

    // T2: dump with ready toggling
    for (int i = 0; i < 32; i++) exp_w[i] = 32'(i * 3);
    start_dump();
    chk("t2 busy after start", 32'(dump_busy), 32'd1);
    collect("t2", 1'b1, 1'b0);

    // T3: CPU writes to words 5 and 6 while word 5 is in SEND
    snapshot();
    exp_w[6] = 32'h0000BEEF;
    start_dump();
    collect("t3", 1'b0, 1'b1);

    // T4: reset in SEND of word 10, restart, extra start while busy
    dump_ready = 1'b1;
    start_dump();
    for (int n = 0; n < 200 && !(dump_valid && dump_addr == 32'd40); n++) cyc();
    chk("t4 reached word10", 32'(dump_valid && dump_addr == 32'd40), 32'd1);
    dump_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t4 rst valid", 32'(dump_valid), 32'd0);
    chk("t4 rst busy", 32'(dump_busy), 32'd0);
    chk("t4 rst done", 32'(dump_done), 32'd0);
    chk("t4 rst addr", dump_addr, 32'd0);
    chk("t4 rst data", dump_data, 32'd0);
    snapshot();
    start_dump();
    cyc();
    cyc();
    start_dump();
    collect("t4", 1'b0, 1'b0);
    for (int n = 0; n < 6; n++) cyc();
    chk("t4 start not queued", 32'(dump_busy), 32'd0);
    chk("t4 idle valid", 32'(dump_valid), 32'd0);

    // T1/T5/T6 and extra lane cases
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].wdata, tbl[i].dwe);
      daddr = tbl[i].raddr;
      #1;
      chk($sformatf("tbl%0d rd", i), drdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d err", i), 32'(err_misalign), 32'(tbl[i].exp_err));
    end

    // Randomized CPU traffic on a small aliased window
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] r;
      a = $urandom;
      a[13:2] = 12'($urandom_range(0, 63));
      wr(a, $urandom, 4'($urandom_range(0, 15)));
      r = $urandom;
      r[13:2] = 12'($urandom_range(0, 63));
      daddr = r;
      #1;
      chk($sformatf("rnd%0d rd", i), drdata, m_mem[r[13:2]]);
      chk($sformatf("rnd%0d err", i), 32'(err_misalign), 32'(m_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
